mc_control_fsm: RTL and testbench
=================================

MC_CONTROL_FSM -- requirements
Module: mc_control_fsm

Interface
REQ-001 Clock and reset SHALL be one clock and an asynchronous, active-low reset. `clk` is the only clock. `reset` asserts asynchronously when low and releases synchronously to `clk`.
REQ-002 Ports SHALL be, clock and reset first:
  clk         in   1   system clock
  reset       in   1   async active-low reset
  Op          in   2   Instr[27:26]
  Funct       in   6   Instr[25:20]
  Rd          in   4   Instr[15:12]
  IsLMul      in   1   decoded long-multiply (Op=00, Instr[7:4]=1001, Instr[23]=1)
  CondEx      in   1   condition check passed for current instruction
  PCWrite     out  1   PC register enable
  RegWrite    out  1   integer regfile write
  MemWrite    out  1   memory write
  FpuWrite    out  1   FPU regfile write
  IRWrite     out  1   instruction register enable
  AdrSrc      out  1   0=PC, 1=ALUOut/Result
  ALUSrcA     out  2   00=A, 01=PC
  ALUSrcB     out  2   00=RD2, 01=ExtImm, 10=const 4
  ResultSrc   out  2   00=ALUOut, 01=Data, 10=ALUResult
  ALUOp       out  1   0=force ADD, 1=decode from Funct
  lmulFlag    out  1   dual-write of {wa3,wa4} for long multiply
  State       out  4   current state encoding (debug)
  InstrCount  out  32  retired-instruction counter

Function
REQ-003 States and encodings SHALL be: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECR=6, EXECI=7, ALUWB=8, LMULWB=9, BRANCH=10, FPEXEC=11, FPWB=12. Codes 13-15 SHALL go to FETCH on the next edge.
REQ-004 Transitions SHALL be:
  - FETCH->DECODE.
  - DECODE: Op=01->MEMADR; Op=00 & Funct[5]=0->EXECR; Op=00 & Funct[5]=1->EXECI; Op=10->BRANCH; Op=11->FPEXEC.
  - MEMADR: Funct[0]=1->MEMRD, else MEMWR.
  - MEMRD->MEMWB.
  - EXECR/EXECI: IsLMul->LMULWB, else ALUWB.
  - FPEXEC->FPWB.
  - MEMWB, MEMWR, ALUWB, LMULWB, BRANCH, FPWB->FETCH.
REQ-005 Outputs SHALL be Moore decodes of state. Any signal not listed for a state is 0.
  - FETCH: IRWrite=1, AdrSrc=0, ALUSrcA=01, ALUSrcB=10, ALUOp=0, ResultSrc=10, NextPC=1.
  - DECODE: ALUSrcA=01, ALUSrcB=10, ResultSrc=10.
  - MEMADR: ALUSrcA=00, ALUSrcB=01, ALUOp=0.
  - MEMRD: AdrSrc=1.
  - MEMWB: ResultSrc=01, RegW=1.
  - MEMWR: AdrSrc=1, MemW=1.
  - EXECR: ALUSrcB=00, ALUOp=1.
  - EXECI: ALUSrcB=01, ALUOp=1.
  - ALUWB: ResultSrc=00, RegW=1 unless Funct[4:3]=2'b10 (compare/test: RegW=0).
  - LMULWB: ResultSrc=00, RegW=1, lmulFlag=1.
  - BRANCH: ALUSrcA=00, ALUSrcB=01, ResultSrc=10, Branch=1.
  - FPEXEC: all 0.
  - FPWB: FpuW=1.
REQ-006 Write gating SHALL be:
  - RegWrite = RegW & CondEx.
  - MemWrite = MemW & CondEx.
  - FpuWrite = FpuW & CondEx.
  - PCWrite = NextPC | (Branch & CondEx) | (RegW & CondEx & Rd==4'hF).
REQ-007 IRWrite and NextPC in FETCH SHALL NOT be gated by CondEx.
REQ-008 A failed condition SHALL NOT alter the state sequence; only the gated writes are suppressed.
REQ-009 lmulFlag SHALL be 1 only in LMULWB, and RegWrite and lmulFlag SHALL assert in the same cycle.
REQ-010 Latencies in cycles, FETCH inclusive, SHALL be: LDR 5, STR 4, ALU 4, long multiply 4, branch 3, FPU 4. FPEXEC exists so the FPU operand and result registers each load exactly once before FpuWrite.
REQ-011 InstrCount SHALL increment by 1 on each clock edge that leaves a terminal state (MEMWB, MEMWR, ALUWB, LMULWB, BRANCH, FPWB), whether or not CondEx passed. It wraps from 32'hFFFFFFFF to 0.
REQ-012 Inputs SHALL be sampled only in DECODE, MEMADR, EXECR/EXECI and the write-back states. Input changes in other states SHALL have no effect.

Reset
REQ-013 While reset=0: State=FETCH and InstrCount=0, asynchronously. All outputs take FETCH decode values, with IRWrite and PCWrite forced to 0 until reset=1.
REQ-014 Reset asserted mid-instruction SHALL abort it with no further RegWrite, MemWrite or FpuWrite. The first cycle after release SHALL be FETCH with IRWrite=1.

Verification
REQ-015 Release reset, Op=00, Funct=6'b101000, Rd=3, CondEx=1 -> states 0,1,7,8,0; RegWrite=1 only in state 8; InstrCount=1.
REQ-016 LDR: Op=01, Funct[0]=1, Rd=15 -> states 0,1,2,3,4; in state 4 ResultSrc=01 and PCWrite=RegWrite=1.
REQ-017 Branch with CondEx=0 -> states 0,1,10,0; PCWrite=0 in BRANCH; InstrCount still increments.
REQ-018 Op=11, CondEx=1 -> states 0,1,11,12; FpuWrite=1 only in state 12; RegWrite=0 throughout.
REQ-019 IsLMul=1, Op=00, Funct[5]=0 -> states 6,9; in state 9 lmulFlag=RegWrite=1; CMP (Funct=6'b010101) -> RegWrite=0 in ALUWB.
REQ-020 Assert reset during MEMWR -> MemWrite drops immediately and State=0. Preload InstrCount near 32'hFFFFFFFF and retire one instruction -> wraps to 0.

Source files
------------

// File: rtl/mc_control_fsm.sv
// ---------------------------------------------------------------------------
// mc_control_fsm
//
// Main control FSM for a multicycle ARM-style core with a long-multiply and an
// FPU extension. It walks each instruction through FETCH, DECODE, an execute
// or address step and a write-back step. Datapath controls are Moore decodes
// of the current state. Architectural writes are gated by the condition
// check. A free-running counter counts retired instructions.
//
// Ports
//   clk        : system clock
//   reset      : asynchronous active-low reset, released synchronously to clk
//   Op         : Instr[27:26] instruction class
//   Funct      : Instr[25:20]
//   Rd         : Instr[15:12] destination register
//   IsLMul     : decoded long-multiply instruction
//   CondEx     : condition check passed for the current instruction
//   PCWrite    : PC register enable
//   RegWrite   : integer register file write enable
//   MemWrite   : data memory write enable
//   FpuWrite   : FPU register file write enable
//   IRWrite    : instruction register enable
//   AdrSrc     : memory address select (0=PC, 1=ALUOut/Result)
//   ALUSrcA    : ALU A operand select (00=A, 01=PC)
//   ALUSrcB    : ALU B operand select (00=RD2, 01=ExtImm, 10=const 4)
//   ResultSrc  : result select (00=ALUOut, 01=Data, 10=ALUResult)
//   ALUOp      : 0=force ADD, 1=decode from Funct
//   lmulFlag   : dual write of {wa3,wa4} for long multiply
//   State      : current state encoding (debug)
//   InstrCount : retired-instruction counter
// ---------------------------------------------------------------------------
module mc_control_fsm (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  Op,
    input  logic [5:0]  Funct,
    input  logic [3:0]  Rd,
    input  logic        IsLMul,
    input  logic        CondEx,
    output logic        PCWrite,
    output logic        RegWrite,
    output logic        MemWrite,
    output logic        FpuWrite,
    output logic        IRWrite,
    output logic        AdrSrc,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ResultSrc,
    output logic        ALUOp,
    output logic        lmulFlag,
    output logic [3:0]  State,
    output logic [31:0] InstrCount
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_EXECI  = 4'd7,
        S_ALUWB  = 4'd8,
        S_LMULWB = 4'd9,
        S_BRANCH = 4'd10,
        S_FPEXEC = 4'd11,
        S_FPWB   = 4'd12
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] instr_count_q, instr_count_d;

    // Ungated per-state intents; the condition check is applied afterwards.
    logic reg_w, mem_w, fpu_w, next_pc, branch, ir_write;
    logic retire;

    // Funct[2:1] select nothing in this controller.
    logic funct_unused;
    assign funct_unused = ^Funct[2:1];

    // State register and retired-instruction counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_FETCH;
            instr_count_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            instr_count_q <= instr_count_d;
        end
    end

    // Next-state logic. Unused codes 13-15 fall into the default and
    // recover to FETCH.
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (Op)
                    2'b00:   state_d = Funct[5] ? S_EXECI : S_EXECR;
                    2'b01:   state_d = S_MEMADR;
                    2'b10:   state_d = S_BRANCH;
                    default: state_d = S_FPEXEC;
                endcase
            end
            S_MEMADR: state_d = Funct[0] ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_d = S_MEMWB;
            S_EXECR,
            S_EXECI:  state_d = IsLMul ? S_LMULWB : S_ALUWB;
            S_FPEXEC: state_d = S_FPWB;
            default:  state_d = S_FETCH;
        endcase
    end

    // Every terminal state retires its instruction on the edge that leaves
    // it, regardless of whether the condition check passed.
    always_comb begin
        retire = 1'b0;
        case (state_q)
            S_MEMWB, S_MEMWR, S_ALUWB,
            S_LMULWB, S_BRANCH, S_FPWB: retire = 1'b1;
            default:                    retire = 1'b0;
        endcase
        instr_count_d = instr_count_q;
        if (retire) begin
            instr_count_d = instr_count_q + 32'd1;
        end
    end

    // Moore output decode.
    always_comb begin
        ir_write  = 1'b0;
        next_pc   = 1'b0;
        reg_w     = 1'b0;
        mem_w     = 1'b0;
        fpu_w     = 1'b0;
        branch    = 1'b0;
        AdrSrc    = 1'b0;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        ResultSrc = 2'b00;
        ALUOp     = 1'b0;
        lmulFlag  = 1'b0;
        case (state_q)
            S_FETCH: begin
                ir_write  = 1'b1;
                next_pc   = 1'b1;
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            S_DECODE: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            S_MEMADR: begin
                ALUSrcB = 2'b01;
            end
            S_MEMRD: begin
                AdrSrc = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                reg_w     = 1'b1;
            end
            S_MEMWR: begin
                AdrSrc = 1'b1;
                mem_w  = 1'b1;
            end
            S_EXECR: begin
                ALUOp = 1'b1;
            end
            S_EXECI: begin
                ALUSrcB = 2'b01;
                ALUOp   = 1'b1;
            end
            S_ALUWB: begin
                // Compare/test operations only update flags.
                reg_w = (Funct[4:3] != 2'b10);
            end
            S_LMULWB: begin
                reg_w    = 1'b1;
                lmulFlag = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                branch    = 1'b1;
            end
            S_FPWB: begin
                fpu_w = 1'b1;
            end
            default: begin
                ir_write = 1'b0;
            end
        endcase
    end

    // Architectural writes are gated by the condition check. The fetch-side
    // enables are not, but they are held off while reset is asserted.
    assign RegWrite   = reg_w & CondEx;
    assign MemWrite   = mem_w & CondEx;
    assign FpuWrite   = fpu_w & CondEx;
    assign IRWrite    = ir_write & reset;
    assign PCWrite    = reset & (next_pc | (branch & CondEx)
                                 | (reg_w & CondEx & (Rd == 4'hF)));
    assign State      = state_q;
    assign InstrCount = instr_count_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// ---------------------------------------------------------------------------
// tb_mc_control_fsm
//
// Directed bench for mc_control_fsm. Each step drives one instruction's
// inputs, queues the expected per-cycle outputs and then compares them cycle
// by cycle half a clock away from the active edge.
// ---------------------------------------------------------------------------
module tb_mc_control_fsm;

    logic        clk;
    logic        reset;
    logic [1:0]  Op;
    logic [5:0]  Funct;
    logic [3:0]  Rd;
    logic        IsLMul;
    logic        CondEx;
    logic        PCWrite, RegWrite, MemWrite, FpuWrite, IRWrite, AdrSrc;
    logic [1:0]  ALUSrcA, ALUSrcB, ResultSrc;
    logic        ALUOp, lmulFlag;
    logic [3:0]  State;
    logic [31:0] InstrCount;

    typedef struct packed {
        logic [3:0]  state;
        logic        irW;
        logic        adr;
        logic [1:0]  srcA;
        logic [1:0]  srcB;
        logic [1:0]  res;
        logic        aluOp;
        logic        lmul;
        logic        regW;
        logic        memW;
        logic        fpuW;
        logic        pcW;
        logic [31:0] cnt;
    } obs_t;

    obs_t        expQ[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] expCnt;

    mc_control_fsm dut (
        .clk        (clk),
        .reset      (reset),
        .Op         (Op),
        .Funct      (Funct),
        .Rd         (Rd),
        .IsLMul     (IsLMul),
        .CondEx     (CondEx),
        .PCWrite    (PCWrite),
        .RegWrite   (RegWrite),
        .MemWrite   (MemWrite),
        .FpuWrite   (FpuWrite),
        .IRWrite    (IRWrite),
        .AdrSrc     (AdrSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ResultSrc  (ResultSrc),
        .ALUOp      (ALUOp),
        .lmulFlag   (lmulFlag),
        .State      (State),
        .InstrCount (InstrCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Mux selects per state: {AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp}.
    function automatic logic [7:0] ctlFor(input logic [3:0] st);
        case (st)
            4'd0:    ctlFor = 8'b0_01_10_10_0;
            4'd1:    ctlFor = 8'b0_01_10_10_0;
            4'd2:    ctlFor = 8'b0_00_01_00_0;
            4'd3:    ctlFor = 8'b1_00_00_00_0;
            4'd4:    ctlFor = 8'b0_00_00_01_0;
            4'd5:    ctlFor = 8'b1_00_00_00_0;
            4'd6:    ctlFor = 8'b0_00_00_00_1;
            4'd7:    ctlFor = 8'b0_00_01_00_1;
            4'd10:   ctlFor = 8'b0_00_01_10_0;
            default: ctlFor = 8'b0_00_00_00_0;
        endcase
    endfunction

    task automatic pushExp(input logic [3:0] st, input logic irW, input logic regW,
                           input logic memW, input logic fpuW, input logic pcW,
                           input logic lmul, input logic [31:0] cnt);
        obs_t e;
        e.state = st;
        {e.adr, e.srcA, e.srcB, e.res, e.aluOp} = ctlFor(st);
        e.irW  = irW;
        e.lmul = lmul;
        e.regW = regW;
        e.memW = memW;
        e.fpuW = fpuW;
        e.pcW  = pcW;
        e.cnt  = cnt;
        expQ.push_back(e);
    endtask

    task automatic pushFetch(input logic [31:0] cnt);
        pushExp(4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, cnt);
    endtask

    task automatic pushQuiet(input logic [3:0] st, input logic [31:0] cnt);
        pushExp(st, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, cnt);
    endtask

    task automatic applyStimulus(input logic [1:0] op, input logic [5:0] funct,
                                 input logic [3:0] rd, input logic isLMul,
                                 input logic condEx);
        Op     = op;
        Funct  = funct;
        Rd     = rd;
        IsLMul = isLMul;
        CondEx = condEx;
    endtask

    // Drains the queue one cycle per entry; returns in the cycle of the last
    // entry.
    task automatic checkOutput(input string tag);
        obs_t e;
        obs_t o;
        int   idx = 0;
        while (expQ.size() > 0) begin
            if (idx > 0) @(negedge clk);
            #1;
            e = expQ.pop_front();
            o.state = State;
            o.irW   = IRWrite;
            o.adr   = AdrSrc;
            o.srcA  = ALUSrcA;
            o.srcB  = ALUSrcB;
            o.res   = ResultSrc;
            o.aluOp = ALUOp;
            o.lmul  = lmulFlag;
            o.regW  = RegWrite;
            o.memW  = MemWrite;
            o.fpuW  = FpuWrite;
            o.pcW   = PCWrite;
            o.cnt   = InstrCount;
            checks++;
            assert (o === e) else begin
                errors++;
                $error("[TB] FAIL %s[%0d] observed=%h expected=%h", tag, idx, o, e);
            end
            idx++;
        end
    endtask

    initial begin
        reset = 1'b0;
        applyStimulus(2'b00, 6'b000000, 4'd0, 1'b0, 1'b0);
        expCnt = 32'd0;
        repeat (2) @(negedge clk);

        // Held in reset: FETCH decode with IRWrite/PCWrite suppressed.
        pushExp(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        checkOutput("reset");

        // ALU immediate, Rd=3.
        reset = 1'b1;
        applyStimulus(2'b00, 6'b101000, 4'd3, 1'b0, 1'b1);
        pushFetch(expCnt);
        pushQuiet(4'd1, expCnt);
        pushQuiet(4'd7, expCnt);
        pushExp(4'd8, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, expCnt);
        checkOutput("alu_imm");
        expCnt++;
        @(negedge clk);

        // LDR into PC.
        applyStimulus(2'b01, 6'b000001, 4'hF, 1'b0, 1'b1);
        pushFetch(expCnt);
        pushQuiet(4'd1, expCnt);
        pushQuiet(4'd2, expCnt);
        pushQuiet(4'd3, expCnt);
        pushExp(4'd4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, expCnt);
        checkOutput("ldr_pc");
        expCnt++;
        @(negedge clk);

        // Branch not taken: fetch still writes PC, BRANCH does not.
        applyStimulus(2'b10, 6'b000000, 4'd0, 1'b0, 1'b0);
        pushFetch(expCnt);
        pushQuiet(4'd1, expCnt);
        pushQuiet(4'd10, expCnt);
        checkOutput("branch_nc");
        expCnt++;
        @(negedge clk);

        // Branch taken.
        applyStimulus(2'b10, 6'b000000, 4'd0, 1'b0, 1'b1);
        pushFetch(expCnt);
        pushQuiet(4'd1, expCnt);
        pushExp(4'd10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, expCnt);
        checkOutput("branch");
        expCnt++;
        @(negedge clk);

        // FPU op.
        applyStimulus(2'b11, 6'b000000, 4'd3, 1'b0, 1'b1);
        pushFetch(expCnt);
        pushQuiet(4'd1, expCnt);
        pushQuiet(4'd11, expCnt);
        pushExp(4'd12, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, expCnt);
        checkOutput("fpu");
        expCnt++;
        @(negedge clk);

        // FPU op, condition failed.
        applyStimulus(2'b11, 6'b000000, 4'd3, 1'b0, 1'b0);
        pushFetch(expCnt);
        pushQuiet(4'd1, expCnt);
        pushQuiet(4'd11, expCnt);
        pushQuiet(4'd12, expCnt);
        checkOutput("fpu_nc");
        expCnt++;
        @(negedge clk);

        // Long multiply via register execute.
        applyStimulus(2'b00, 6'b001000, 4'd2, 1'b1, 1'b1);
        pushFetch(expCnt);
        pushQuiet(4'd1, expCnt);
        pushQuiet(4'd6, expCnt);
        pushExp(4'd9, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, expCnt);
        checkOutput("lmul");
        expCnt++;
        @(negedge clk);

        // CMP: no register write.
        applyStimulus(2'b00, 6'b010101, 4'd3, 1'b0, 1'b1);
        pushFetch(expCnt);
        pushQuiet(4'd1, expCnt);
        pushQuiet(4'd6, expCnt);
        pushQuiet(4'd8, expCnt);
        checkOutput("cmp");
        expCnt++;
        @(negedge clk);

        // ALU register op into PC, condition failed.
        applyStimulus(2'b00, 6'b000100, 4'hF, 1'b0, 1'b0);
        pushFetch(expCnt);
        pushQuiet(4'd1, expCnt);
        pushQuiet(4'd6, expCnt);
        pushQuiet(4'd8, expCnt);
        checkOutput("alu_pc_nc");
        expCnt++;
        @(negedge clk);

        // ALU immediate into PC.
        applyStimulus(2'b00, 6'b100100, 4'hF, 1'b0, 1'b1);
        pushFetch(expCnt);
        pushQuiet(4'd1, expCnt);
        pushQuiet(4'd7, expCnt);
        pushExp(4'd8, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, expCnt);
        checkOutput("alu_pc");
        expCnt++;
        @(negedge clk);

        // STR.
        applyStimulus(2'b01, 6'b000000, 4'd5, 1'b0, 1'b1);
        pushFetch(expCnt);
        pushQuiet(4'd1, expCnt);
        pushQuiet(4'd2, expCnt);
        pushExp(4'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, expCnt);
        checkOutput("str");
        expCnt++;
        @(negedge clk);

        // STR, condition failed.
        applyStimulus(2'b01, 6'b000000, 4'd5, 1'b0, 1'b0);
        pushFetch(expCnt);
        pushQuiet(4'd1, expCnt);
        pushQuiet(4'd2, expCnt);
        pushQuiet(4'd5, expCnt);
        checkOutput("str_nc");
        expCnt++;
        @(negedge clk);

        // STR aborted by reset in MEMWR.
        applyStimulus(2'b01, 6'b000000, 4'd5, 1'b0, 1'b1);
        pushFetch(expCnt);
        pushQuiet(4'd1, expCnt);
        pushQuiet(4'd2, expCnt);
        pushExp(4'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, expCnt);
        checkOutput("abort_pre");
        #1;
        reset = 1'b0;
        pushExp(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        checkOutput("abort");
        @(negedge clk);
        pushExp(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        checkOutput("abort_hold");
        @(negedge clk);

        // Release, preload the counter just below wrap, retire a branch.
        reset = 1'b1;
        applyStimulus(2'b10, 6'b000000, 4'd0, 1'b0, 1'b1);
        force dut.instr_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.instr_count_q;
        expCnt = 32'hFFFF_FFFF;
        pushFetch(expCnt);
        pushQuiet(4'd1, expCnt);
        pushExp(4'd10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, expCnt);
        checkOutput("wrap_pre");
        expCnt++;
        @(negedge clk);
        pushFetch(expCnt);
        checkOutput("wrap");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
